sha256_digest_collector: RTL and testbench
==========================================

// Module: sha256_digest_collector
// PURPOSE
//  Receives the SHA-256 digest streamed by the hash core, 16 bits per cycle, most significant word first.
//  Reassembles the 16 words into one 256-bit digest and holds it for a downstream consumer.
//  The hold uses a valid/ready handshake and flags overruns and stalled streams.
//  Sits directly after the hash core output, in front of result registers or the host interface.
// PARAMETERS
//  WORD_W       16   width of each incoming digest word
//  DIGEST_W     256  assembled digest width; NUM_WORDS = DIGEST_W/WORD_W = 16
//  TIMEOUT_CYC  64   maximum idle cycles between words inside a digest; 0 disables the timeout
// PORTS
//  clk            in   1         clock
//  reset          in   1         asynchronous, active-high
//  hash_valid     in   1         hash_word carries a digest word this cycle
//  hash_word      in   WORD_W    digest word; the first word is digest[255:240]
//  hash_ready     out  1         collector accepts a word this cycle
//  digest         out  DIGEST_W  assembled digest; stable while digest_valid=1
//  digest_valid   out  1         digest complete and held
//  digest_ready   in   1         consumer takes the digest
//  expected_digest in  DIGEST_W  reference digest for compare; must be stable from first word to acceptance
//  digest_match   out  1         digest equals expected_digest; meaningful only while digest_valid=1
//  word_count     out  5         words accepted so far in the current digest, 0..16
//  overrun_err    out  1         sticky: a word was offered while hash_ready=0
//  timeout_err    out  1         one-cycle pulse: partial digest discarded on timeout
//  clr_err        in   1         synchronous clear of overrun_err
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, gap counter 0. hash_ready rises on the first clk edge after reset deasserts.
//  States:
//   IDLE: hash_ready=1. A word is accepted when hash_valid=1. It shifts into the assembly register; word_count=1; go to COLLECT.
//   COLLECT: hash_ready=1. Each accepted word shifts left by WORD_W and word_count increments.
//    When the 16th word is accepted, the next state is HOLD. digest_valid=1 from the following cycle (1-cycle latency).
//   HOLD: hash_ready=0. digest, digest_match and word_count=16 are held stable.
//    digest_valid && digest_ready -> IDLE, with word_count=0 and hash_ready=1 on the next cycle.
//  Gap timer: counts consecutive COLLECT cycles with hash_valid=0; resets on every accepted word.
//   When the count reaches TIMEOUT_CYC: timeout_err pulses 1 cycle, the assembly register clears, word_count=0, go to IDLE.
//   A word arriving on the timeout cycle is dropped and does not set overrun_err.
//  Overrun: hash_valid=1 while hash_ready=0 sets overrun_err; the word is discarded.
//   This includes the cycle of the digest_ready handshake and the first cycle after reset.
//   overrun_err clears only on clr_err or reset. If clr_err and a new overrun occur in the same cycle, set wins.
//  word_count never wraps: 16 only in HOLD; a 17th word is impossible because hash_ready=0.
//  Reset asserted mid-digest discards the partial digest immediately. There is no partial output.
//  Arithmetic: shift-in only, no adders except the 5-bit word counter and the gap counter ($clog2(TIMEOUT_CYC+1) bits).
// CONFIGURATION
//  SHA256_COMPARE_EN defined:
//   digest_match is registered on the edge that accepts the 16th word.
//   It compares the final assembled value against expected_digest in that cycle, and is held through HOLD.
//   It clears to 0 on leaving HOLD.
//  SHA256_COMPARE_EN undefined:
//   No comparator is built and digest_match is tied to 0.
//   expected_digest stays in the port list and is ignored.
// STRUCTURE
//  Package sha256_pkg contains:
//   WORD_W, DIGEST_W, NUM_WORDS
//   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} collector_state_t
//   DIGEST_ABC and DIGEST_EMPTY constants for benches
//  Sub-module sha256_gap_timer: gap counter with clear/enable inputs and a terminal-count output.
// TESTING
//  Abc digest:
//   stimulus: reset, then 16 back-to-back words ba78,16bf,8f01,cfea,4141,40de,5dae,2223,b003,61a3,9617,7a9c,b410,ff61,f200,15ad
//   response: digest_valid one cycle after the last word; digest=256'hba7816bf...f20015ad; digest_match=1 with expected_digest equal to it
//  Empty-string digest with gaps: stream e3b0c442..7852b855 with 3 idle cycles between words, TIMEOUT_CYC=64 -> no timeout; digest correct.
//  Mismatch: abc stream with expected_digest = empty digest -> digest_match=0. With SHA256_COMPARE_EN undefined -> digest_match always 0.
//  Backpressure:
//   stimulus: hold digest_ready=0 for 10 cycles and drive hash_valid=1 with word 0x1234 during HOLD
//   response: overrun_err=1, digest unchanged; clr_err -> overrun_err=0
//  Timeout: accept 5 words, then idle 64 cycles -> timeout_err pulses once, word_count=0, next 16 words assemble a fresh digest.
//  Reset mid-digest: assert reset after word 8 -> all outputs 0; a full 16-word stream afterwards yields the correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 digest collector.
package sha256_pkg;

  localparam int WORD_W    = 16;
  localparam int DIGEST_W  = 256;
  localparam int NUM_WORDS = DIGEST_W / WORD_W;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } collector_state_t;

  localparam logic [DIGEST_W-1:0] DIGEST_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [DIGEST_W-1:0] DIGEST_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

endpackage

// File: rtl/sha256_gap_timer.sv
// Idle-gap counter; tc holds while the count equals TIMEOUT_CYC.
// TIMEOUT_CYC = 0 removes the counter and tc never asserts.
module sha256_gap_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, reset, clear, enable};
      assign tc = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable && !tc) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign tc = (cnt == CW'(TIMEOUT_CYC));
    end
  endgenerate

endmodule

// File: rtl/sha256_digest_collector.sv
// Reassembles a 16x16-bit SHA-256 digest stream and holds it for a consumer.
// Optional digest comparator: define SHA256_COMPARE_EN.
module sha256_digest_collector
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hash_valid,
  input  logic [WORD_W-1:0]   hash_word,
  output logic                hash_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  input  logic [DIGEST_W-1:0] expected_digest,
  output logic                digest_match,
  output logic [CNT_W-1:0]    word_count,
  output logic                overrun_err,
  output logic                timeout_err,
  input  logic                clr_err
);

  collector_state_t    state;
  logic [DIGEST_W-1:0] asm_q;
  logic [DIGEST_W-1:0] asm_next;
  logic                tc;
  logic                timeout_hit;
  logic                accept;
  logic                last_word;
  logic                gap_clear;
  logic                gap_en;

  assign timeout_hit = (state == COLLECT) && tc;
  assign accept      = hash_valid && hash_ready && !timeout_hit;
  assign asm_next    = {asm_q[DIGEST_W-WORD_W-1:0], hash_word};
  assign last_word   = (word_count == CNT_W'(NUM_WORDS - 1));
  assign gap_clear   = accept || (state != COLLECT) || tc;
  assign gap_en      = (state == COLLECT) && !hash_valid;
  assign digest      = asm_q;

  sha256_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clear (gap_clear),
    .enable(gap_en),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hash_ready   <= 1'b0;
      asm_q        <= '0;
      word_count   <= '0;
      digest_valid <= 1'b0;
      timeout_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      // a new overrun beats a simultaneous clear
      if (hash_valid && !hash_ready) begin
        overrun_err <= 1'b1;
      end else if (clr_err) begin
        overrun_err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          hash_ready <= 1'b1;
          if (accept) begin
            asm_q      <= asm_next;
            word_count <= CNT_W'(1);
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (timeout_hit) begin
            timeout_err <= 1'b1;
            asm_q       <= '0;
            word_count  <= '0;
            state       <= IDLE;
          end else if (accept) begin
            asm_q      <= asm_next;
            word_count <= word_count + 5'd1;
            if (last_word) begin
              hash_ready   <= 1'b0;
              digest_valid <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (digest_ready) begin
            hash_ready   <= 1'b1;
            digest_valid <= 1'b0;
            word_count   <= '0;
            asm_q        <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA256_COMPARE_EN
  logic match_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
    end else if (state == COLLECT && accept && last_word) begin
      match_q <= (asm_next == expected_digest);
    end else if (state == HOLD && digest_ready) begin
      match_q <= 1'b0;
    end
  end

  assign digest_match = match_q;
`else
  logic unused_expected;
  assign unused_expected = ^expected_digest;
  assign digest_match    = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_digest_collector.sv
// Bench for sha256_digest_collector: vector table plus
// hand-written overrun, timeout and reset sequences.
module tb_sha256_digest_collector;
  import sha256_pkg::*;

  logic                clk;
  logic                reset;
  logic                hash_valid;
  logic [WORD_W-1:0]   hash_word;
  logic                hash_ready;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                digest_ready;
  logic [DIGEST_W-1:0] expected_digest;
  logic                digest_match;
  logic [CNT_W-1:0]    word_count;
  logic                overrun_err;
  logic                timeout_err;
  logic                clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DIGEST_W-1:0] stream;
    logic [DIGEST_W-1:0] expect_in;
    int                  gap;
  } vec_t;

  typedef struct {
    logic [DIGEST_W-1:0] d;
    logic                m;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];

  sha256_digest_collector #(
    .TIMEOUT_CYC(64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hash_valid     (hash_valid),
    .hash_word      (hash_word),
    .hash_ready     (hash_ready),
    .digest         (digest),
    .digest_valid   (digest_valid),
    .digest_ready   (digest_ready),
    .expected_digest(expected_digest),
    .digest_match   (digest_match),
    .word_count     (word_count),
    .overrun_err    (overrun_err),
    .timeout_err    (timeout_err),
    .clr_err        (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic match_of(input logic [255:0] d,
                                    input logic [255:0] e);
`ifdef SHA256_COMPARE_EN
    return d == e;
`else
    return 1'b0;
`endif
  endfunction

  // scoreboard: pop on every digest handshake
  always @(negedge clk) begin
    if (!reset && digest_valid && digest_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got digest %0h expected none", digest);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_digest", digest, e.d);
        check("sb_match", digest_match, e.m);
        check("sb_count", word_count, 16);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    hash_valid = 1'b0;
    while (!hash_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("ready_wait", hash_ready, 1);
    hash_word  = w;
    hash_valid = 1'b1;
    tick();
    hash_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [255:0] d, input int gap);
    for (int i = 0; i < 16; i++) begin
      send_word(d[255-16*i -: 16]);
      if (i < 15) repeat (gap) tick();
    end
    check("valid_latency", digest_valid, 1);
    check("hold_count", word_count, 16);
    check("hold_ready", hash_ready, 0);
  endtask

  task automatic accept_digest();
    int n = 0;
    while (!digest_valid && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("valid_wait", digest_valid, 1);
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    check("post_valid", digest_valid, 0);
    check("post_count", word_count, 0);
    check("post_ready", hash_ready, 1);
    check("post_match", digest_match, 0);
  endtask

  initial begin
    vecs[0] = '{DIGEST_ABC, DIGEST_ABC, 0};
    vecs[1] = '{DIGEST_EMPTY, DIGEST_EMPTY, 3};
    vecs[2] = '{DIGEST_ABC, DIGEST_EMPTY, 0};
    vecs[3] = '{
      256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0,
      256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0,
      1};

    reset           = 1'b1;
    hash_valid      = 1'b0;
    hash_word       = '0;
    digest_ready    = 1'b0;
    expected_digest = '0;
    clr_err         = 1'b0;
    repeat (3) tick();

    check("rst_ready", hash_ready, 0);
    check("rst_valid", digest_valid, 0);
    check("rst_count", word_count, 0);
    check("rst_digest", digest, 0);
    check("rst_match", digest_match, 0);
    check("rst_ovr", overrun_err, 0);
    check("rst_tmo", timeout_err, 0);

    reset = 1'b0;
    #1;
    check("ready_before_edge", hash_ready, 0);

    // word offered on the first cycle after reset is an overrun
    hash_valid = 1'b1;
    hash_word  = 16'hdead;
    tick();
    hash_valid = 1'b0;
    check("first_cyc_ovr", overrun_err, 1);
    check("first_cyc_count", word_count, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("first_cyc_clr", overrun_err, 0);
    check("first_cyc_ready", hash_ready, 1);

    for (int v = 0; v < 4; v++) begin
      expected_digest = vecs[v].expect_in;
      sb.push_back('{vecs[v].stream,
                     match_of(vecs[v].stream, vecs[v].expect_in)});
      send_stream(vecs[v].stream, vecs[v].gap);
      check("vec_tmo", timeout_err, 0);
      repeat (2) tick();
      accept_digest();
    end

    // backpressure and overrun while holding
    expected_digest = DIGEST_ABC;
    sb.push_back('{DIGEST_ABC, match_of(DIGEST_ABC, DIGEST_ABC)});
    send_stream(DIGEST_ABC, 0);
    hash_word  = 16'h1234;
    hash_valid = 1'b1;
    repeat (10) tick();
    hash_valid = 1'b0;
    check("bp_ovr", overrun_err, 1);
    check("bp_digest", digest, DIGEST_ABC);
    check("bp_count", word_count, 16);
    check("bp_valid", digest_valid, 1);
    clr_err    = 1'b1;
    hash_valid = 1'b1;
    tick();
    hash_valid = 1'b0;
    check("bp_set_wins", overrun_err, 1);
    tick();
    clr_err = 1'b0;
    check("bp_clr", overrun_err, 0);
    hash_valid   = 1'b1;
    digest_ready = 1'b1;
    tick();
    hash_valid   = 1'b0;
    digest_ready = 1'b0;
    check("hs_ovr", overrun_err, 1);
    check("hs_count", word_count, 0);
    check("hs_valid", digest_valid, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // timeout on a partial digest
    begin
      int pulses = 0;
      int first  = -1;
      for (int i = 0; i < 5; i++) send_word(DIGEST_EMPTY[255-16*i -: 16]);
      check("tmo_partial", word_count, 5);
      for (int c = 1; c <= 100; c++) begin
        tick();
        if (timeout_err) begin
          pulses++;
          if (first < 0) first = c;
        end
      end
      check("tmo_pulses", pulses, 1);
      check("tmo_window", (first >= 64 && first <= 66), 1);
      check("tmo_count", word_count, 0);
      check("tmo_ready", hash_ready, 1);
      check("tmo_ovr", overrun_err, 0);
    end
    expected_digest = DIGEST_ABC;
    sb.push_back('{DIGEST_ABC, match_of(DIGEST_ABC, DIGEST_ABC)});
    send_stream(DIGEST_ABC, 0);
    accept_digest();

    // reset mid-digest
    for (int i = 0; i < 8; i++) send_word(DIGEST_ABC[255-16*i -: 16]);
    check("mid_count", word_count, 8);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_count", word_count, 0);
    check("mid_rst_digest", digest, 0);
    check("mid_rst_ready", hash_ready, 0);
    check("mid_rst_valid", digest_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    expected_digest = DIGEST_EMPTY;
    sb.push_back('{DIGEST_EMPTY, match_of(DIGEST_EMPTY, DIGEST_EMPTY)});
    send_stream(DIGEST_EMPTY, 0);
    accept_digest();

    repeat (2) tick();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
